sm_to_fp_encoder: RTL

- Downstream consumer of the two's-complement to sign-magnitude converter. Takes its sign bit and 11-bit magnitude and produces the compact float: sign S, 3-bit exponent E, 4-bit significand F, with value = F * 2^E.
- Normalisation is iterative, one left-shift per clock, with round-to-nearest (half up) on the first discarded bit.
- Uses a valid/ready handshake on both sides so it can sit between the converter register and the display/output stage.

---
 rtl/sm_fp_pkg.sv | 29 ++
 rtl/sm_to_fp_encoder_round.sv | 46 ++++
 rtl/sm_to_fp_encoder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sm_fp_pkg.sv
// Shared definitions for the sign-magnitude to compact-float encoder.
//
// Contents:
//   state_e   - encoder FSM states (IDLE/NORM/ROUND/DONE), 2-bit encoding
//   MAG_W     - magnitude width delivered by the upstream converter
//   EXP_W     - exponent width of the compact float
//   SIG_W     - significand width of the compact float
//   EXP_MAX   - largest representable exponent (all ones)
//   FR_LSB    - bit index of the lowest kept fraction bit in the work register
//   RND_IDX   - bit index of the round bit (first discarded bit)
package sm_fp_pkg;

  localparam int unsigned MAG_W = 11;
  localparam int unsigned EXP_W = 3;
  localparam int unsigned SIG_W = 4;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  localparam int unsigned FR_LSB  = MAG_W - SIG_W;
  localparam int unsigned RND_IDX = MAG_W - SIG_W - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sm_to_fp_encoder_round.sv
// fp_round: combinational round-to-nearest (half up) step of the encoder.
//
// Ports:
//   fr       in   SIG_W  kept fraction bits of the normalised magnitude
//   rb       in   1      round bit (first discarded bit)
//   E        in   EXP_W  exponent reached by normalisation
//   F_next   out  SIG_W  rounded significand
//   E_next   out  EXP_W  exponent after a possible mantissa carry
//   sat_next out  1      rounding overflowed the largest representable value
module fp_round
  import sm_fp_pkg::*;
(
  input  logic [SIG_W-1:0] fr,
  input  logic             rb,
  input  logic [EXP_W-1:0] E,
  output logic [SIG_W-1:0] F_next,
  output logic [EXP_W-1:0] E_next,
  output logic             sat_next
);

  // One extra bit so the carry out of fr+1 is visible.
  logic [SIG_W:0] fr_inc;

  always_comb begin
    fr_inc   = {1'b0, fr} + {{SIG_W{1'b0}}, 1'b1};
    F_next   = fr;
    E_next   = E;
    sat_next = 1'b0;

    if (rb) begin
      if (!fr_inc[SIG_W]) begin
        F_next = fr_inc[SIG_W-1:0];
      end else if (E != EXP_MAX) begin
        // Carry out of the significand: renormalise to 1000b, bump exponent.
        F_next = {1'b1, {(SIG_W-1){1'b0}}};
        E_next = E + EXP_W'(1);
      end else begin
        // No exponent headroom left: clamp to the largest value.
        F_next   = '1;
        E_next   = EXP_MAX;
        sat_next = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sm_to_fp_encoder.sv
// sm_to_fp_encoder: turns a sign/magnitude pair into a compact float
// S, E, F with value F * 2^E. The magnitude is normalised one left
// shift per clock (at most EXP_MAX shifts), then rounded half-up on the
// first discarded bit. valid/ready handshakes on both sides; one
// conversion in flight at a time.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      signbit/SM valid
//   in_ready   out  1      encoder idle and able to accept
//   signbit    in   1      sign from upstream
//   SM         in   MAG_W  unsigned magnitude (1024 legal)
//   out_valid  out  1      S/E/F/sat hold a finished result
//   out_ready  in   1      consumer takes the result
//   S          out  1      result sign
//   E          out  EXP_W  result exponent
//   F          out  SIG_W  result significand
//   sat        out  1      rounding saturated at E=EXP_MAX, F=all ones
module sm_to_fp_encoder
  import sm_fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             signbit,
  input  logic [MAG_W-1:0] SM,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             S,
  output logic [EXP_W-1:0] E,
  output logic [SIG_W-1:0] F,
  output logic             sat
);

  state_e           state_q, state_d;
  logic [MAG_W-1:0] work_q, work_d;
  logic             s_q, s_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic [SIG_W-1:0] f_q, f_d;
  logic             sat_q, sat_d;

  logic [SIG_W-1:0] rnd_f;
  logic [EXP_W-1:0] rnd_e;
  logic             rnd_sat;

  fp_round u_fp_round (
    .fr       (work_q[MAG_W-1:FR_LSB]),
    .rb       (work_q[RND_IDX]),
    .E        (e_q),
    .F_next   (rnd_f),
    .E_next   (rnd_e),
    .sat_next (rnd_sat)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      s_q     <= 1'b0;
      e_q     <= '0;
      f_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      s_q     <= s_d;
      e_q     <= e_d;
      f_q     <= f_d;
      sat_q   <= sat_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    s_d     = s_q;
    e_d     = e_q;
    f_d     = f_q;
    sat_d   = sat_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = SM;
          s_d     = signbit;
          e_d     = EXP_MAX;
          state_d = NORM;
        end
      end

      NORM: begin
        // Exponent floor is checked before shifting so E never wraps.
        if (work_q[MAG_W-1] || (e_q == '0)) begin
          state_d = ROUND;
        end else begin
          work_d = {work_q[MAG_W-2:0], 1'b0};
          e_d    = e_q - EXP_W'(1);
        end
      end

      ROUND: begin
        f_d     = rnd_f;
        e_d     = rnd_e;
        sat_d   = rnd_sat;
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) begin
          sat_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    S         = s_q;
    E         = e_q;
    F         = f_q;
    sat       = sat_q;
  end

endmodule
